// File: rtl/multicycle_control_pkg.sv
// Shared constants for the multicycle MIPS control unit: opcode and funct
// values, ALUOp codes, datapath select encodings and the FSM state encoding.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FUNCT_JR = 6'h08;

    // 3-bit ALU codes; zero-extended to the configured ALUOp width.
    localparam logic [2:0] ALU_NONE  = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_ADD   = 3'b100;
    localparam logic [2:0] ALU_OR    = 3'b101;
    localparam logic [2:0] ALU_LUI   = 3'b110;
    localparam logic [2:0] ALU_RTYPE = 3'b111;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;

    localparam logic [1:0] DST_RT    = 2'b00;
    localparam logic [1:0] DST_RD    = 2'b01;
    localparam logic [1:0] DST_RA    = 2'b10;

    localparam logic [1:0] SRCB_REGB = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM4 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REGA   = 2'b11;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEM_ADDR = 4'd3,
        ST_MEM_RD   = 4'd4,
        ST_MEM_WB   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_EXEC_R   = 4'd7,
        ST_WB_R     = 4'd8,
        ST_EXEC_I   = 4'd9,
        ST_WB_I     = 4'd10,
        ST_BRANCH   = 4'd11,
        ST_JUMP     = 4'd12,
        ST_JAL      = 4'd13,
        ST_JR       = 4'd14,
        ST_HALT     = 4'd15
    } state_e;

    // Smallest counter width that can hold the timeout limit (at least 1 bit).
    function automatic int timer_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Instruction-field inputs, memory handshake and datapath control outputs of
// the multicycle control unit. master = controller, slave = datapath side.
interface multicycle_control_if #(
    parameter int ALUOP_WIDTH = 4
);
    logic [5:0]             OP;
    logic [5:0]             Funct;
    logic                   MemReady;

    logic                   PCWrite;
    logic                   BranchEQ;
    logic                   BranchNE;
    logic                   IorD;
    logic                   MemRead;
    logic                   MemWrite;
    logic                   IRWrite;
    logic                   ALUSrcA;
    logic                   RegWrite;
    logic [1:0]             MemtoReg;
    logic [1:0]             RegDst;
    logic [1:0]             ALUSrcB;
    logic [1:0]             PCSource;
    logic [ALUOP_WIDTH-1:0] ALUOp;
    logic                   IllegalOp;
    logic                   MemFault;
    logic [3:0]             State;

    modport master (
        input  OP, Funct, MemReady,
        output PCWrite, BranchEQ, BranchNE, IorD, MemRead, MemWrite, IRWrite,
               ALUSrcA, RegWrite, MemtoReg, RegDst, ALUSrcB, PCSource, ALUOp,
               IllegalOp, MemFault, State
    );

    modport slave (
        output OP, Funct, MemReady,
        input  PCWrite, BranchEQ, BranchNE, IorD, MemRead, MemWrite, IRWrite,
               ALUSrcA, RegWrite, MemtoReg, RegDst, ALUSrcB, PCSource, ALUOp,
               IllegalOp, MemFault, State
    );
endinterface

// File: rtl/multicycle_control_mem_timer.sv
// Memory wait-cycle counter. Counts cycles spent stalled in a memory state and
// flags a timeout on the stall cycle that brings the count to MEM_TIMEOUT.
module control_mem_timer
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic wait_i,
    input  logic ready_i,
    output logic timeout_o
);

    localparam int              CNT_W   = timer_width(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] LAST    = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A memory state is only held while MemReady is low, so any other cycle
    // clears the count; every entry into a wait state therefore starts at 0.
    always_comb begin
        cnt_d = '0;
        if (wait_i && !ready_i) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_o = (MEM_TIMEOUT > 0) && wait_i && !ready_i && (cnt_q >= LAST);

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS datapath.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   IDLE     | after reset, no strobes
//   FETCH    | read instruction, PC+4, wait for MemReady
//   DECODE   | branch target into ALUOut, dispatch on OP/Funct
//   MEM_ADDR | compute load/store address
//   MEM_RD   | load data read, wait for MemReady
//   MEM_WB   | write loaded data to rt
//   MEM_WR   | store, wait for MemReady
//   EXEC_R   | R-type ALU operation
//   WB_R     | write ALU result to rd
//   EXEC_I   | immediate ALU operation
//   WB_I     | write ALU result to rt
//   BRANCH   | compare and conditionally take BEQ/BNE
//   JUMP     | load jump target
//   JAL      | load jump target, link PC into $ra
//   JR       | load PC from regA
//   HALT     | illegal opcode or memory timeout, until reset
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int ALUOP_WIDTH = 4,
    parameter int MEM_TIMEOUT = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);

    state_e     state_q;
    state_e     state_d;
    logic       illegal_q;
    logic       illegal_d;
    logic       fault_q;
    logic       fault_d;
    logic       in_wait;
    logic       timeout;

    logic       pc_write;
    logic       branch_eq;
    logic       branch_ne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       alu_src_a;
    logic       reg_write;
    logic [1:0] memto_reg;
    logic [1:0] reg_dst;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_code;

    assign in_wait = (state_q == ST_FETCH) || (state_q == ST_MEM_RD) || (state_q == ST_MEM_WR);

    control_mem_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .wait_i   (in_wait),
        .ready_i  (bus.MemReady),
        .timeout_o(timeout)
    );

    // State and sticky fault flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            illegal_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            fault_q   <= fault_d;
        end
    end

    // Next-state and per-state datapath controls.
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        fault_d   = fault_q;
        pc_write  = 1'b0;
        branch_eq = 1'b0;
        branch_ne = 1'b0;
        iord      = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        alu_src_a = 1'b0;
        reg_write = 1'b0;
        memto_reg = WB_ALUOUT;
        reg_dst   = DST_RT;
        alu_src_b = SRCB_REGB;
        pc_source = PCSRC_ALU;
        alu_code  = ALU_NONE;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                alu_code  = ALU_ADD;
                ir_write  = bus.MemReady;
                pc_write  = bus.MemReady;
                // A completing access takes priority over a timeout in the same cycle.
                if (bus.MemReady) begin
                    state_d = ST_DECODE;
                end else if (timeout) begin
                    state_d = ST_HALT;
                    fault_d = 1'b1;
                end
            end
            ST_DECODE: begin
                alu_src_b = SRCB_IMM4;
                alu_code  = ALU_ADD;
                case (bus.OP)
                    OP_LW, OP_SW:                     state_d = ST_MEM_ADDR;
                    OP_ADDI, OP_ORI, OP_ANDI, OP_LUI: state_d = ST_EXEC_I;
                    OP_BEQ, OP_BNE:                   state_d = ST_BRANCH;
                    OP_J:                             state_d = ST_JUMP;
                    OP_JAL:                           state_d = ST_JAL;
                    OP_RTYPE: begin
                        state_d = (bus.Funct == FUNCT_JR) ? ST_JR : ST_EXEC_R;
                    end
                    default: begin
                        state_d   = ST_HALT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            ST_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_code  = ALU_ADD;
                state_d   = (bus.OP == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            end
            ST_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (bus.MemReady) begin
                    state_d = ST_MEM_WB;
                end else if (timeout) begin
                    state_d = ST_HALT;
                    fault_d = 1'b1;
                end
            end
            ST_MEM_WB: begin
                reg_write = 1'b1;
                memto_reg = WB_MDR;
                reg_dst   = DST_RT;
                state_d   = ST_FETCH;
            end
            ST_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (bus.MemReady) begin
                    state_d = ST_FETCH;
                end else if (timeout) begin
                    state_d = ST_HALT;
                    fault_d = 1'b1;
                end
            end
            ST_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_REGB;
                alu_code  = ALU_RTYPE;
                state_d   = ST_WB_R;
            end
            ST_WB_R: begin
                reg_write = 1'b1;
                reg_dst   = DST_RD;
                memto_reg = WB_ALUOUT;
                state_d   = ST_FETCH;
            end
            ST_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                case (bus.OP)
                    OP_ORI:  alu_code = ALU_OR;
                    OP_ANDI: alu_code = ALU_AND;
                    OP_LUI:  alu_code = ALU_LUI;
                    default: alu_code = ALU_ADD;
                endcase
                state_d = ST_WB_I;
            end
            ST_WB_I: begin
                reg_write = 1'b1;
                reg_dst   = DST_RT;
                state_d   = ST_FETCH;
            end
            ST_BRANCH: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_REGB;
                alu_code  = ALU_SUB;
                pc_source = PCSRC_ALUOUT;
                branch_eq = (bus.OP == OP_BEQ);
                branch_ne = (bus.OP == OP_BNE);
                state_d   = ST_FETCH;
            end
            ST_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
                state_d   = ST_FETCH;
            end
            ST_JAL: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
                reg_write = 1'b1;
                reg_dst   = DST_RA;
                memto_reg = WB_PC;
                state_d   = ST_FETCH;
            end
            ST_JR: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_REGA;
                state_d   = ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.PCWrite   = pc_write;
    assign bus.BranchEQ  = branch_eq;
    assign bus.BranchNE  = branch_ne;
    assign bus.IorD      = iord;
    assign bus.MemRead   = mem_read;
    assign bus.MemWrite  = mem_write;
    assign bus.IRWrite   = ir_write;
    assign bus.ALUSrcA   = alu_src_a;
    assign bus.RegWrite  = reg_write;
    assign bus.MemtoReg  = memto_reg;
    assign bus.RegDst    = reg_dst;
    assign bus.ALUSrcB   = alu_src_b;
    assign bus.PCSource  = pc_source;
    assign bus.ALUOp     = ALUOP_WIDTH'(alu_code);
    assign bus.IllegalOp = illegal_q;
    assign bus.MemFault  = fault_q;
    assign bus.State     = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed instruction scenarios
// followed by random instruction streams with random memory stalls.
module tb_multicycle_control;
    import mips_ctrl_pkg::*;

    localparam int AW  = 4;
    localparam int TMO = 5;

    typedef struct packed {
        logic       pc_write;
        logic       branch_eq;
        logic       branch_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       alu_src_a;
        logic       reg_write;
        logic [1:0] memto_reg;
        logic [1:0] reg_dst;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [3:0] alu_op;
        logic       illegal;
        logic       fault;
        logic [3:0] state;
    } out_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    multicycle_control_if #(.ALUOP_WIDTH(AW)) bus_if ();

    multicycle_control #(
        .ALUOP_WIDTH(AW),
        .MEM_TIMEOUT(TMO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic       m_illegal = 1'b0;
    logic       m_fault   = 1'b0;
    logic [5:0] cur_op    = 6'h00;
    logic [5:0] cur_funct = 6'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic out_t observed();
        out_t o;
        o.pc_write  = bus_if.PCWrite;
        o.branch_eq = bus_if.BranchEQ;
        o.branch_ne = bus_if.BranchNE;
        o.iord      = bus_if.IorD;
        o.mem_read  = bus_if.MemRead;
        o.mem_write = bus_if.MemWrite;
        o.ir_write  = bus_if.IRWrite;
        o.alu_src_a = bus_if.ALUSrcA;
        o.reg_write = bus_if.RegWrite;
        o.memto_reg = bus_if.MemtoReg;
        o.reg_dst   = bus_if.RegDst;
        o.alu_src_b = bus_if.ALUSrcB;
        o.pc_source = bus_if.PCSource;
        o.alu_op    = bus_if.ALUOp;
        o.illegal   = bus_if.IllegalOp;
        o.fault     = bus_if.MemFault;
        o.state     = bus_if.State;
        return o;
    endfunction

    // Control word the datapath should see in a given state.
    function automatic out_t expected(input state_e st, input logic [5:0] op, input logic ready);
        out_t e = '0;
        e.state   = st;
        e.illegal = m_illegal;
        e.fault   = m_fault;
        case (st)
            ST_FETCH: begin
                e.mem_read = 1; e.alu_src_b = 2'b01; e.alu_op = 4'b0100;
                e.ir_write = ready; e.pc_write = ready;
            end
            ST_DECODE:   begin e.alu_src_b = 2'b11; e.alu_op = 4'b0100; end
            ST_MEM_ADDR: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_op = 4'b0100; end
            ST_MEM_RD:   begin e.mem_read = 1; e.iord = 1; end
            ST_MEM_WB:   begin e.reg_write = 1; e.memto_reg = 2'b01; end
            ST_MEM_WR:   begin e.mem_write = 1; e.iord = 1; end
            ST_EXEC_R:   begin e.alu_src_a = 1; e.alu_op = 4'b0111; end
            ST_WB_R:     begin e.reg_write = 1; e.reg_dst = 2'b01; end
            ST_EXEC_I: begin
                e.alu_src_a = 1; e.alu_src_b = 2'b10;
                e.alu_op = (op == 6'h0D) ? 4'b0101 :
                           (op == 6'h0C) ? 4'b0010 :
                           (op == 6'h0F) ? 4'b0110 : 4'b0100;
            end
            ST_WB_I:     begin e.reg_write = 1; end
            ST_BRANCH: begin
                e.alu_src_a = 1; e.alu_op = 4'b0001; e.pc_source = 2'b01;
                e.branch_eq = (op == 6'h04); e.branch_ne = (op == 6'h05);
            end
            ST_JUMP:     begin e.pc_write = 1; e.pc_source = 2'b10; end
            ST_JAL: begin
                e.pc_write = 1; e.pc_source = 2'b10; e.reg_write = 1;
                e.reg_dst = 2'b10; e.memto_reg = 2'b10;
            end
            ST_JR:       begin e.pc_write = 1; e.pc_source = 2'b11; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic compare_now(input string tag, input state_e st, input logic ready);
        out_t o;
        out_t e;
        o = observed();
        e = expected(st, cur_op, ready);
        check(tag, {5'b0, o}, {5'b0, e});
    endtask

    // One clock cycle in which the DUT is expected to sit in state st.
    task automatic step(input state_e st, input logic ready);
        @(negedge clk);
        bus_if.OP       = cur_op;
        bus_if.Funct    = cur_funct;
        bus_if.MemReady = ready;
        #1;
        compare_now(st.name(), st, ready);
    endtask

    // Memory state with 'waits' stalled cycles; stall number TMO ends in HALT.
    task automatic wait_phase(input state_e st, input int waits, output bit timed_out);
        timed_out = 0;
        for (int i = 0; i <= waits; i++) begin
            if (i == waits) begin
                step(st, 1'b1);
            end else begin
                step(st, 1'b0);
                if (TMO > 0 && i + 1 == TMO) begin
                    timed_out = 1;
                    break;
                end
            end
        end
    endtask

    // Asynchronous reset mid-cycle, then release and observe the IDLE cycle.
    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        m_illegal = 1'b0;
        m_fault   = 1'b0;
        compare_now("reset_async", ST_IDLE, bus_if.MemReady);
        check("memwrite_at_reset", 32'(bus_if.MemWrite), 32'd0);
        @(posedge clk);
        #1;
        compare_now("reset_hold", ST_IDLE, bus_if.MemReady);
        reset = 1'b0;
        step(ST_IDLE, 1'($urandom_range(0, 1)));
    endtask

    task automatic halt_and_reset();
        for (int i = 0; i < 3; i++) step(ST_HALT, 1'($urandom_range(0, 1)));
        do_reset();
    endtask

    // Runs one instruction from FETCH to its last state as the spec describes.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] funct, input int wf, input int wm);
        bit to;
        cur_op    = op;
        cur_funct = funct;
        wait_phase(ST_FETCH, wf, to);
        if (to) begin m_fault = 1'b1; halt_and_reset(); return; end
        step(ST_DECODE, 1'($urandom_range(0, 1)));
        case (op)
            6'h23: begin
                step(ST_MEM_ADDR, 1'($urandom_range(0, 1)));
                wait_phase(ST_MEM_RD, wm, to);
                if (to) begin m_fault = 1'b1; halt_and_reset(); return; end
                step(ST_MEM_WB, 1'($urandom_range(0, 1)));
            end
            6'h2B: begin
                step(ST_MEM_ADDR, 1'($urandom_range(0, 1)));
                wait_phase(ST_MEM_WR, wm, to);
                if (to) begin m_fault = 1'b1; halt_and_reset(); return; end
            end
            6'h08, 6'h0C, 6'h0D, 6'h0F: begin
                step(ST_EXEC_I, 1'($urandom_range(0, 1)));
                step(ST_WB_I, 1'($urandom_range(0, 1)));
            end
            6'h04, 6'h05: step(ST_BRANCH, 1'($urandom_range(0, 1)));
            6'h02:        step(ST_JUMP, 1'($urandom_range(0, 1)));
            6'h03:        step(ST_JAL, 1'($urandom_range(0, 1)));
            6'h00: begin
                if (funct == 6'h08) begin
                    step(ST_JR, 1'($urandom_range(0, 1)));
                end else begin
                    step(ST_EXEC_R, 1'($urandom_range(0, 1)));
                    step(ST_WB_R, 1'($urandom_range(0, 1)));
                end
            end
            default: begin
                m_illegal = 1'b1;
                halt_and_reset();
            end
        endcase
    endtask

    function automatic int rand_wait();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 2));
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         to;
        int         idx;
        logic [5:0] op;
        logic [5:0] funct;

        bus_if.OP       = 6'h00;
        bus_if.Funct    = 6'h00;
        bus_if.MemReady = 1'b0;
        do_reset();

        run_instr(6'h08, 6'h00, 0, 0);      // ADDI, no stalls
        run_instr(6'h23, 6'h00, 0, 3);      // LW, 3 stalls in MEM_RD
        run_instr(6'h05, 6'h00, 1, 0);      // BNE
        run_instr(6'h04, 6'h00, 0, 0);      // BEQ
        run_instr(6'h00, 6'h08, 0, 0);      // JR
        run_instr(6'h00, 6'h20, 2, 0);      // R-type
        run_instr(6'h03, 6'h00, 0, 0);      // JAL
        run_instr(6'h2B, 6'h00, 0, TMO - 1); // SW, ready on the last allowed cycle
        run_instr(6'h3F, 6'h00, 0, 0);      // illegal opcode -> HALT
        run_instr(6'h08, 6'h00, 7, 0);      // FETCH stall -> timeout
        run_instr(6'h23, 6'h00, 0, TMO);    // MEM_RD stall -> timeout

        // Reset while a store is waiting on memory.
        cur_op = 6'h2B;
        cur_funct = 6'h00;
        wait_phase(ST_FETCH, 0, to);
        step(ST_DECODE, 1'b0);
        step(ST_MEM_ADDR, 1'b0);
        step(ST_MEM_WR, 1'b0);
        step(ST_MEM_WR, 1'b0);
        do_reset();

        for (int n = 0; n < 80; n++) begin
            idx   = int'($urandom_range(0, 12));
            funct = 6'($urandom_range(0, 63));
            case (idx)
                0:  op = 6'h23;
                1:  op = 6'h2B;
                2:  op = 6'h08;
                3:  op = 6'h0D;
                4:  op = 6'h0C;
                5:  op = 6'h0F;
                6:  op = 6'h04;
                7:  op = 6'h05;
                8:  op = 6'h02;
                9:  op = 6'h03;
                10: op = 6'h00;
                11: begin op = 6'h00; funct = 6'h08; end
                default: op = ($urandom_range(0, 1) == 0) ? 6'h3F : 6'h11;
            endcase
            run_instr(op, funct, rand_wait(), rand_wait());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
